// File: rtl/ws281x_chain_driver.sv
// WS281x/SK6812 one-wire chain driver: fetches pixels, scales, reorders and
// emits the NRZ bit stream followed by the latch gap.
module ws281x_chain_driver #(
  parameter int unsigned NUM_LEDS = 16,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned T_BIT    = 62,
  parameter int unsigned T1H      = 39,
  parameter int unsigned T0H      = 19,
  parameter int unsigned T_RESET  = 2600,
  localparam int unsigned AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [7:0]            i_brightness,
  input  logic [1:0]            i_order,
  output logic [AW-1:0]         o_pixel_addr,
  output logic                  o_pixel_rd,
  input  logic [8*CHANNELS-1:0] i_pixel_data,
  output logic                  o_dout,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int unsigned BITS    = 8 * CHANNELS;
  localparam int unsigned BIT_W   = $clog2(BITS);
  localparam int unsigned CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t            r_state,      w_state;
  logic [CNT_W-1:0]  r_cnt,        w_cnt;
  logic [BIT_W-1:0]  r_bit_idx,    w_bit_idx;
  logic [AW-1:0]     r_led,        w_led;
  logic [BITS-1:0]   r_shift,      w_shift;
  logic [BITS-1:0]   r_hold,       w_hold;
  logic              r_hold_pend,  w_hold_pend;
  logic              r_fetch_wait, w_fetch_wait;
  logic [7:0]        r_bright,     w_bright;
  logic [1:0]        r_order,      w_order;
  logic [AW-1:0]     r_pixel_addr, w_pixel_addr;
  logic              r_pixel_rd,   w_pixel_rd;
  logic              r_dout,       w_dout;
  logic              r_busy,       w_busy;
  logic              r_frame_done, w_frame_done;

  logic [BITS-1:0]   w_word;
  logic [CNT_W-1:0]  w_high_len;

  // Scale one channel by (brightness+1)/256; 255 is identity, 0 blanks.
  function automatic logic [7:0] scale8(input logic [7:0] ch, input logic [7:0] br);
    logic [15:0] prod;
    prod = 16'(ch) * (16'(br) + 16'd1);
    return prod[15:8];
  endfunction

  // Scale every channel and arrange colour bytes in wire order, white last.
  function automatic logic [BITS-1:0] build_word(input logic [BITS-1:0] pd,
                                                 input logic [7:0]      br,
                                                 input logic [1:0]      ord);
    logic [7:0]  r, g, b, w;
    logic [23:0] rgb;
    r = scale8(pd[BITS-1 -: 8], br);
    g = scale8(pd[BITS-9 -: 8], br);
    b = scale8(pd[BITS-17 -: 8], br);
    w = scale8(pd[7:0], br);
    case (ord)
      2'd0:    rgb = {g, r, b};
      2'd1:    rgb = {r, g, b};
      2'd2:    rgb = {b, r, g};
      default: rgb = {b, g, r};
    endcase
    return BITS'({rgb, w} >> (8 * (4 - CHANNELS)));
  endfunction

  assign w_word     = build_word(i_pixel_data, r_bright, r_order);
  assign w_high_len = r_shift[BITS-1] ? CNT_W'(T1H) : CNT_W'(T0H);

  // Next-state and next-output logic.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_bit_idx    = r_bit_idx;
    w_led        = r_led;
    w_shift      = r_shift;
    w_hold       = r_hold;
    w_hold_pend  = r_pixel_rd && (r_state == S_SEND);
    w_fetch_wait = r_fetch_wait;
    w_bright     = r_bright;
    w_order      = r_order;
    w_pixel_addr = r_pixel_addr;
    w_pixel_rd   = 1'b0;
    w_dout       = 1'b0;
    w_busy       = r_busy;
    w_frame_done = 1'b0;

    if (r_hold_pend) begin
      w_hold = w_word;
    end

    case (r_state)
      S_IDLE: begin
        w_pixel_addr = '0;
        if (i_start) begin
          w_bright     = i_brightness;
          w_order      = i_order;
          w_pixel_rd   = 1'b1;
          w_busy       = 1'b1;
          w_fetch_wait = 1'b0;
          w_state      = S_FETCH;
        end
      end

      S_FETCH: begin
        if (!r_fetch_wait) begin
          w_fetch_wait = 1'b1;
        end else begin
          w_fetch_wait = 1'b0;
          w_shift      = w_word;
          w_cnt        = '0;
          w_bit_idx    = '0;
          w_led        = '0;
          w_dout       = 1'b1;
          w_state      = S_SEND;
          if (NUM_LEDS > 1) begin
            w_pixel_rd   = 1'b1;
            w_pixel_addr = AW'(1);
          end
        end
      end

      S_SEND: begin
        if (r_cnt == CNT_W'(T_BIT - 1)) begin
          w_cnt = '0;
          if (r_bit_idx == BIT_W'(BITS - 1)) begin
            if (r_led == AW'(NUM_LEDS - 1)) begin
              w_state = S_LATCH;
            end else begin
              // Seamless hand-over to the prefetched pixel.
              w_shift   = r_hold;
              w_led     = r_led + AW'(1);
              w_bit_idx = '0;
              w_dout    = 1'b1;
              if ((32'(r_led) + 32'd2) < NUM_LEDS) begin
                w_pixel_rd   = 1'b1;
                w_pixel_addr = AW'(32'(r_led) + 32'd2);
              end
            end
          end else begin
            w_shift   = {r_shift[BITS-2:0], 1'b0};
            w_bit_idx = r_bit_idx + BIT_W'(1);
            w_dout    = 1'b1;
          end
        end else begin
          w_cnt  = r_cnt + CNT_W'(1);
          w_dout = (r_cnt + CNT_W'(1)) < w_high_len;
        end
      end

      S_LATCH: begin
        if (r_cnt == CNT_W'(T_RESET - 1)) begin
          w_cnt        = '0;
          w_bit_idx    = '0;
          w_led        = '0;
          w_pixel_addr = '0;
          w_busy       = 1'b0;
          w_frame_done = 1'b1;
          w_state      = S_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_led        <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_pend  <= 1'b0;
      r_fetch_wait <= 1'b0;
      r_bright     <= '0;
      r_order      <= '0;
      r_pixel_addr <= '0;
      r_pixel_rd   <= 1'b0;
      r_dout       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_bit_idx    <= w_bit_idx;
      r_led        <= w_led;
      r_shift      <= w_shift;
      r_hold       <= w_hold;
      r_hold_pend  <= w_hold_pend;
      r_fetch_wait <= w_fetch_wait;
      r_bright     <= w_bright;
      r_order      <= w_order;
      r_pixel_addr <= w_pixel_addr;
      r_pixel_rd   <= w_pixel_rd;
      r_dout       <= w_dout;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
    end
  end

  assign o_pixel_addr = r_pixel_addr;
  assign o_pixel_rd   = r_pixel_rd;
  assign o_dout       = r_dout;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_ws281x_chain_driver.sv
// Bench for ws281x_chain_driver: an RGB 4-LED chain and an RGBW single-LED
// chain, checked cycle by cycle against an arithmetic waveform model.
module tb_ws281x_chain_driver;

  localparam int NA  = 4;
  localparam int CA  = 3;
  localparam int NB  = 1;
  localparam int CB  = 4;
  localparam int TBT = 10;
  localparam int T1  = 6;
  localparam int T0  = 3;
  localparam int TR  = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [7:0]  bright;
  logic [1:0]  order;
  logic [1:0]  addr_a;
  logic [0:0]  addr_b;
  logic        rd_a, rd_b, dout_a, dout_b, busy_a, busy_b, done_a, done_b;
  logic [23:0] pdata_a;
  logic [31:0] pdata_b;
  logic [23:0] mem_a [NA];
  logic [31:0] mem_b [NB];
  logic [31:0] d0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ws281x_chain_driver #(.NUM_LEDS(NA), .CHANNELS(CA), .T_BIT(TBT), .T1H(T1),
                        .T0H(T0), .T_RESET(TR)) u_dut_a (
    .clk(clk), .reset(reset), .i_start(start_a), .i_brightness(bright),
    .i_order(order), .o_pixel_addr(addr_a), .o_pixel_rd(rd_a),
    .i_pixel_data(pdata_a), .o_dout(dout_a), .o_busy(busy_a),
    .o_frame_done(done_a));

  ws281x_chain_driver #(.NUM_LEDS(NB), .CHANNELS(CB), .T_BIT(TBT), .T1H(T1),
                        .T0H(T0), .T_RESET(TR)) u_dut_b (
    .clk(clk), .reset(reset), .i_start(start_b), .i_brightness(bright),
    .i_order(order), .o_pixel_addr(addr_b), .o_pixel_rd(rd_b),
    .i_pixel_data(pdata_b), .o_dout(dout_b), .o_busy(busy_b),
    .o_frame_done(done_b));

  // Synchronous pixel stores; data is garbage except the cycle after a read.
  always @(posedge clk) begin
    if (rd_a) pdata_a <= mem_a[addr_a];
    else      pdata_a <= 24'($urandom);
    if (rd_b) pdata_b <= mem_b[addr_b];
    else      pdata_b <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected wire word for one LED, built from plain byte arithmetic.
  function automatic logic [31:0] model_word(input logic [31:0] pix, input int ch,
                                             input int br, input int ord);
    int c [4];
    int s [4];
    int idx [3];
    logic [31:0] wd;
    if (ch == 3) begin
      c[0] = int'(pix[23:16]); c[1] = int'(pix[15:8]); c[2] = int'(pix[7:0]); c[3] = 0;
    end else begin
      c[0] = int'(pix[31:24]); c[1] = int'(pix[23:16]); c[2] = int'(pix[15:8]); c[3] = int'(pix[7:0]);
    end
    for (int i = 0; i < 4; i++) s[i] = (c[i] * (br + 1)) / 256;
    case (ord)
      0:       idx = '{1, 0, 2};
      1:       idx = '{0, 1, 2};
      2:       idx = '{2, 0, 1};
      default: idx = '{2, 1, 0};
    endcase
    wd = 32'd0;
    for (int j = 0; j < 3; j++) wd = (wd << 8) | 32'(s[idx[j]]);
    if (ch == 4) wd = (wd << 8) | 32'(s[3]);
    return wd;
  endfunction

  // Runs one frame on instance `which` and checks every cycle until frame_done.
  task automatic run_frame(input int which, input logic [7:0] br, input logic [1:0] ord,
                           input bit hold, output logic [31:0] dec0);
    int n, ch, bits, blen, dlen, s, led, bp, ph, exp_addr, saddr;
    int e_dout, e_rd, e_addr, e_busy, e_done;
    logic [31:0] words [4];
    logic [31:0] dec [4];
    logic b, exp_d, exp_rd, sd, srd, sbusy, sdone;
    n    = which ? NB : NA;
    ch   = which ? CB : CA;
    bits = 8 * ch;
    blen = bits * TBT;
    dlen = 3 + n * blen + TR;
    for (int i = 0; i < 4; i++) begin
      dec[i]   = 32'd0;
      words[i] = 32'd0;
      if (i < n) begin
        if (which != 0) words[i] = model_word(mem_b[i], ch, int'(br), int'(ord));
        else            words[i] = model_word(32'(mem_a[i]), ch, int'(br), int'(ord));
      end
    end
    e_dout = 0; e_rd = 0; e_addr = 0; e_busy = 0; e_done = 0;
    bright = br;
    order  = ord;
    if (which != 0) start_b = 1'b1;
    else            start_a = 1'b1;
    for (int k = 1; k <= dlen; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        if (!hold) begin
          start_a = 1'b0;
          start_b = 1'b0;
        end
        bright = 8'($urandom);
        order  = 2'($urandom);
      end
      sd    = which ? dout_b : dout_a;
      srd   = which ? rd_b   : rd_a;
      sbusy = which ? busy_b : busy_a;
      sdone = which ? done_b : done_a;
      saddr = which ? int'(addr_b) : int'(addr_a);
      exp_d    = 1'b0;
      exp_rd   = (k == 1);
      exp_addr = 0;
      if (k >= 3 && k < 3 + n * blen) begin
        s     = k - 3;
        led   = s / blen;
        bp    = (s / TBT) % bits;
        ph    = s % TBT;
        b     = words[led][bits - 1 - bp];
        exp_d = (ph < (b ? T1 : T0));
        if (ph == T0) dec[led][bits - 1 - bp] = sd;
        if ((s % blen) == 0 && led < n - 1) begin
          exp_rd   = 1'b1;
          exp_addr = led + 1;
        end
      end
      if (sd !== exp_d) e_dout++;
      if (srd !== exp_rd) e_rd++;
      if (exp_rd && saddr != exp_addr) e_addr++;
      if (k == dlen && saddr != 0) e_addr++;
      if (sbusy !== (k < dlen)) e_busy++;
      if (sdone !== (k == dlen)) e_done++;
    end
    check($sformatf("dout_wave_%0d", which), 32'(e_dout), 32'd0);
    check($sformatf("pixel_rd_%0d", which), 32'(e_rd), 32'd0);
    check($sformatf("pixel_addr_%0d", which), 32'(e_addr), 32'd0);
    check($sformatf("busy_%0d", which), 32'(e_busy), 32'd0);
    check($sformatf("frame_done_%0d", which), 32'(e_done), 32'd0);
    for (int i = 0; i < n; i++)
      check($sformatf("led_word_%0d_%0d", which, i), dec[i], words[i]);
    dec0 = dec[0];
    if (e_done != 0) begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  br;
    logic [1:0]  ord;
    logic [23:0] pix;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [8];
  int   quiet;

  initial begin
    tbl[0] = '{8'd255, 2'd0, 24'hFF0000, 24'h00FF00};
    tbl[1] = '{8'd128, 2'd0, 24'h808080, 24'h404040};
    tbl[2] = '{8'd0,   2'd1, 24'h123456, 24'h000000};
    tbl[3] = '{8'd255, 2'd1, 24'h123456, 24'h123456};
    tbl[4] = '{8'd255, 2'd2, 24'h123456, 24'h561234};
    tbl[5] = '{8'd255, 2'd3, 24'h123456, 24'h563412};
    tbl[6] = '{8'd100, 2'd3, 24'hFF8001, 24'h003264};
    tbl[7] = '{8'd1,   2'd0, 24'hFFFFFF, 24'h010101};

    start_a = 1'b0;
    start_b = 1'b0;
    bright  = 8'd0;
    order   = 2'd0;
    reset   = 1'b1;
    for (int i = 0; i < NA; i++) mem_a[i] = 24'($urandom);
    mem_b[0] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout_a", 32'(dout_a), 32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_done_a", 32'(done_a), 32'd0);
    check("reset_rd_a", 32'(rd_a), 32'd0);
    check("reset_addr_a", 32'(addr_a), 32'd0);
    check("reset_dout_b", 32'(dout_b), 32'd0);
    check("reset_busy_b", 32'(busy_b), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven single-word scaling and ordering on LED 0.
    for (int i = 0; i < 8; i++) begin
      mem_a[0] = tbl[i].pix;
      for (int j = 1; j < NA; j++) mem_a[j] = 24'($urandom);
      run_frame(0, tbl[i].br, tbl[i].ord, 1'b0, d0);
      check($sformatf("table_word0_%0d", i), d0, 32'(tbl[i].exp));
    end

    // Address-tagged pixels expose any mis-addressed prefetch.
    for (int j = 0; j < NA; j++) mem_a[j] = 24'(j * 24'h111111);
    run_frame(0, 8'd255, 2'd1, 1'b0, d0);

    // RGBW single LED: white stays last, no prefetch strobe.
    mem_b[0] = 32'h01020304;
    run_frame(1, 8'd255, 2'd3, 1'b0, d0);
    check("rgbw_bgr_word", d0, 32'h03020104);
    mem_b[0] = 32'h80808080;
    run_frame(1, 8'd128, 2'd0, 1'b0, d0);
    check("rgbw_half_word", d0, 32'h40404040);

    // Three back-to-back frames with start held high.
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < NA; j++) mem_a[j] = 24'($urandom);
      run_frame(0, 8'($urandom), 2'($urandom), f < 2, d0);
    end
    quiet = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (rd_a || busy_a || done_a || dout_a) quiet++;
    end
    check("idle_after_b2b", 32'(quiet), 32'd0);

    // Reset in the middle of a bit of LED 2.
    for (int j = 0; j < NA; j++) mem_a[j] = 24'($urandom);
    bright  = 8'd255;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (3 + 2 * CA * 8 * TBT + 5 * TBT + 1 - 1) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_dout", 32'(dout_a), 32'd1);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_reset_dout", 32'(dout_a), 32'd0);
    check("mid_reset_busy", 32'(busy_a), 32'd0);
    check("mid_reset_done", 32'(done_a), 32'd0);
    check("mid_reset_addr", 32'(addr_a), 32'd0);
    quiet = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (rd_a || busy_a || done_a || dout_a) quiet++;
    end
    check("quiet_after_reset", 32'(quiet), 32'd0);
    for (int j = 0; j < NA; j++) mem_a[j] = 24'($urandom);
    run_frame(0, 8'($urandom), 2'($urandom), 1'b0, d0);

    // Randomized frames on both chains.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < NA; j++) mem_a[j] = 24'($urandom);
      run_frame(0, 8'($urandom), 2'($urandom), 1'b0, d0);
    end
    for (int r = 0; r < 4; r++) begin
      mem_b[0] = $urandom;
      run_frame(1, 8'($urandom), 2'($urandom), 1'b0, d0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws281x_chain_driver.md
# ws281x_chain_driver

Parametrised serial driver for WS281x-family addressable LED chains: fetches one pixel per LED from an external synchronous pixel store, applies global brightness scaling and a selectable colour-channel order, and emits the NRZ one-wire waveform followed by the latch gap. Sits between the frame/pixel memory and the LED data pin. Supports RGB (3-channel) and RGBW (4-channel) parts and arbitrary clock rates through count parameters.

## Interface
- NUM_LEDS, 16: LEDs in the chain, ≥1.
- CHANNELS, 3: colour channels per LED, 3 (RGB) or 4 (RGBW).
- T_BIT, 62: clocks per data bit.
- T1H, 39: high clocks for a '1' bit; T0H < T1H < T_BIT.
- T0H, 19: high clocks for a '0' bit; ≥1.
- T_RESET, 2600: low clocks of latch gap after the last bit.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  frame request, sampled in IDLE only.
- brightness  in  8  global scale, sampled at frame start.
- order  in  2  wire order: 0 GRB, 1 RGB, 2 BRG, 3 BGR; sampled at frame start.
- pixel_addr  out  max(1,$clog2(NUM_LEDS))  LED index being read.
- pixel_rd  out  1  one-cycle read strobe.
- pixel_data  in  8*CHANNELS  {R,G,B} or {R,G,B,W}, R in MSBs; valid the cycle after pixel_rd.
- dout  out  1  LED line, registered.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.

## Operation
- All outputs registered; reset values: dout 0, busy 0, frame_done 0, pixel_rd 0, pixel_addr 0; state IDLE, all counters 0.
- States: IDLE → FETCH → SEND → LATCH → IDLE.
- IDLE: start=1 → latch brightness/order, pixel_addr←0, pixel_rd←1, busy←1, go FETCH.
- FETCH: pixel_rd←0; wait one cycle, capture pixel_data into shift register (scaled, reordered), go SEND.
- Scaling per channel: (ch × (brightness+1)) >> 8, 16-bit product, 8-bit result; 255 = identity, 0 = all off. W channel scaled identically.
- Reorder: three colour bytes arranged per order; W (CHANNELS=4) always last. Serialisation MSB first per byte, BITS = 8×CHANNELS bits per LED.
- SEND: each bit lasts T_BIT clocks; dout high for first T1H (bit=1) or T0H (bit=0) clocks, low for the rest.
- Prefetch: in the first cycle of bit 0 of LED k, if k < NUM_LEDS−1, pixel_rd pulses with pixel_addr=k+1; data captured next cycle (scaled, reordered) into a hold register; at end of LED k's last bit the hold register loads the shift register. No idle clocks between LEDs.
- pixel_addr holds its last value between strobes; returns to 0 in IDLE.
- After last bit of LED NUM_LEDS−1 → LATCH: dout low for T_RESET clocks, then frame_done=1 and busy=0 in the same cycle, state IDLE.
- start held high: new frame accepted the cycle after frame_done (back-to-back frames); start ignored outside IDLE.
- reset mid-frame: next edge dout 0, busy 0, no frame_done, IDLE.
- NUM_LEDS=1: no prefetch strobe issued.

## Timing
- start sampled cycle 0 → pixel_rd high cycle 1 → pixel_data valid cycle 2 → first dout rise cycle 3.
- Frame length from first dout rise to frame_done: NUM_LEDS×BITS×T_BIT + T_RESET clocks.
- busy high from cycle 1 through the cycle before frame_done.
- brightness/order changes mid-frame have no effect until next frame.

## Test plan
- NUM_LEDS=1, CHANNELS=3, order=0, brightness=255, pixel {R=FF,G=00,B=00} → 8 high pulses of 19 clocks, 8 of 39, 8 of 19, each period 62; 2600 low; frame_done once; dout rise 3 cycles after start.
- brightness=128, pixel {80,80,80} → each byte sent as 0x40 (01000000); brightness=0 → all 24 bits '0'.
- NUM_LEDS=4, addresses return pixel=addr×0x111111 → pixel_rd strobes at addr 0,1,2,3 only, each at bit 0 of previous LED, no gaps between LEDs, total frame 4×24×62+2600 clocks.
- CHANNELS=4, order=3, pixel {R=01,G=02,B=03,W=04} → wire bytes 03,02,01,04.
- reset asserted mid-bit of LED 2 → dout 0 next edge, busy 0, no frame_done; new start runs clean frame from addr 0.
- start held high for 3 frames → frame_done pulses 3 times, next pixel_rd at addr 0 one cycle after each frame_done.
